// File: rtl/cam_init_seq_if.sv
// rtl/cam_init_seq_if.sv - request/ack bus between the init sequencer and the SCCB master
// Purpose : one SCCB transaction per req/ack handshake.
// Signals : sccb_req   - transaction request, held until sccb_ack
//           sccb_rw    - 0 write, 1 read
//           sccb_addr  - sensor register address
//           sccb_wdata - write data
//           sccb_ack   - one-cycle pulse, transaction finished
//           sccb_nack  - valid with sccb_ack, slave did not acknowledge
//           sccb_rdata - read data, valid with sccb_ack
// Modports: master (sequencer side), slave (SCCB master side)
interface cam_init_seq_if #(
   parameter int REG_AW = 8,
   parameter int DATA_W = 8
) ();
   logic              sccb_req;
   logic              sccb_rw;
   logic [REG_AW-1:0] sccb_addr;
   logic [DATA_W-1:0] sccb_wdata;
   logic              sccb_ack;
   logic              sccb_nack;
   logic [DATA_W-1:0] sccb_rdata;

   modport master (
      output sccb_req, sccb_rw, sccb_addr, sccb_wdata,
      input  sccb_ack, sccb_nack, sccb_rdata
   );

   modport slave (
      input  sccb_req, sccb_rw, sccb_addr, sccb_wdata,
      output sccb_ack, sccb_nack, sccb_rdata
   );
endinterface

// File: rtl/cam_init_seq.sv
// rtl/cam_init_seq.sv - camera init sequencer walking a command ROM into an SCCB master
// Purpose : steps through ROM entries (END / WRITE / DELAY / READ_VERIFY), issues SCCB
//           transactions with NACK retry, and counts failed entries.
// Ports   : clk, rst_n     - clock, asynchronous active-low reset
//           i_start        - one-cycle pulse starting the sequence (IDLE only)
//           o_romaddr      - ROM entry address
//           i_t_cmd/addr/data - combinational ROM entry contents
//           sccb           - request/ack bus to the SCCB master (master modport)
//           o_busy         - high from start accept until DONE
//           o_done         - one-cycle pulse at sequence end
//           o_err_cnt      - saturating count of failed entries
module cam_init_seq #(
   parameter int ROM_AW    = 8,
   parameter int DEPTH     = 96,
   parameter int REG_AW    = 8,
   parameter int DATA_W    = 8,
   parameter int DLY_UNIT  = 24000,
   parameter int DLY_W     = 16,
   parameter int MAX_RETRY = 3,
   parameter int ERR_W     = 4
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                i_start,
   output logic [ROM_AW-1:0]   o_romaddr,
   input  logic [1:0]          i_t_cmd,
   input  logic [REG_AW-1:0]   i_t_addr,
   input  logic [DATA_W-1:0]   i_t_data,
   cam_init_seq_if.master      sccb,
   output logic                o_busy,
   output logic                o_done,
   output logic [ERR_W-1:0]    o_err_cnt
);
   localparam logic [1:0] CMD_END   = 2'd0;
   localparam logic [1:0] CMD_DELAY = 2'd2;
   localparam logic [1:0] CMD_READ  = 2'd3;
   localparam int         RTY_W     = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);

   typedef enum logic [2:0] {
      S_IDLE, S_FETCH, S_ISSUE, S_WAIT, S_DELAY, S_NEXT, S_DONE
   } state_t;

   state_t              r_state,   w_state_nxt;
   logic [ROM_AW-1:0]   r_romaddr, w_romaddr_nxt;
   logic                r_req,     w_req_nxt;
   logic                r_rw,      w_rw_nxt;
   logic [REG_AW-1:0]   r_addr,    w_addr_nxt;
   logic [DATA_W-1:0]   r_wdata,   w_wdata_nxt;
   logic                r_busy,    w_busy_nxt;
   logic                r_done,    w_done_nxt;
   logic [ERR_W-1:0]    r_err_cnt, w_err_cnt_nxt;
   logic [RTY_W-1:0]    r_retry,   w_retry_nxt;
   logic [DATA_W-1:0]   r_ticks,   w_ticks_nxt;
   logic [DLY_W-1:0]    r_dly,     w_dly_nxt;
   logic                w_err_inc;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state   <= S_IDLE;
         r_romaddr <= '0;
         r_req     <= 1'b0;
         r_rw      <= 1'b0;
         r_addr    <= '0;
         r_wdata   <= '0;
         r_busy    <= 1'b0;
         r_done    <= 1'b0;
         r_err_cnt <= '0;
         r_retry   <= '0;
         r_ticks   <= '0;
         r_dly     <= '0;
      end else begin
         r_state   <= w_state_nxt;
         r_romaddr <= w_romaddr_nxt;
         r_req     <= w_req_nxt;
         r_rw      <= w_rw_nxt;
         r_addr    <= w_addr_nxt;
         r_wdata   <= w_wdata_nxt;
         r_busy    <= w_busy_nxt;
         r_done    <= w_done_nxt;
         r_err_cnt <= w_err_cnt_nxt;
         r_retry   <= w_retry_nxt;
         r_ticks   <= w_ticks_nxt;
         r_dly     <= w_dly_nxt;
      end
   end

   always_comb begin
      w_state_nxt   = r_state;
      w_romaddr_nxt = r_romaddr;
      w_req_nxt     = r_req;
      w_rw_nxt      = r_rw;
      w_addr_nxt    = r_addr;
      w_wdata_nxt   = r_wdata;
      w_busy_nxt    = r_busy;
      w_done_nxt    = 1'b0;
      w_err_cnt_nxt = r_err_cnt;
      w_retry_nxt   = r_retry;
      w_ticks_nxt   = r_ticks;
      w_dly_nxt     = r_dly;
      w_err_inc     = 1'b0;

      case (r_state)
         S_IDLE: begin
            if (i_start) begin
               w_romaddr_nxt = '0;
               w_err_cnt_nxt = '0;
               w_busy_nxt    = 1'b1;
               w_state_nxt   = S_FETCH;
            end
         end
         S_FETCH: begin
            if (i_t_cmd == CMD_END) begin
               w_done_nxt  = 1'b1;
               w_state_nxt = S_DONE;
            end else if (i_t_cmd == CMD_DELAY) begin
               if (i_t_data == '0) begin
                  w_state_nxt = S_NEXT;
               end else begin
                  w_ticks_nxt = i_t_data;
                  w_dly_nxt   = '0;
                  w_state_nxt = S_DELAY;
               end
            end else begin
               // For READ_VERIFY the data field is the expected value, parked in wdata.
               w_addr_nxt  = i_t_addr;
               w_wdata_nxt = i_t_data;
               w_rw_nxt    = (i_t_cmd == CMD_READ);
               w_retry_nxt = '0;
               w_state_nxt = S_ISSUE;
            end
         end
         S_ISSUE: begin
            w_req_nxt   = 1'b1;
            w_state_nxt = S_WAIT;
         end
         S_WAIT: begin
            if (sccb.sccb_ack) begin
               w_req_nxt = 1'b0;
               if (!sccb.sccb_nack) begin
                  if (r_rw && (sccb.sccb_rdata != r_wdata)) begin
                     w_err_inc = 1'b1;
                  end
                  w_state_nxt = S_NEXT;
               end else if (r_retry < RTY_W'(MAX_RETRY)) begin
                  w_retry_nxt = r_retry + 1'b1;
                  w_state_nxt = S_ISSUE;
               end else begin
                  w_err_inc   = 1'b1;
                  w_state_nxt = S_NEXT;
               end
            end
         end
         S_DELAY: begin
            // r_dly counts cycles within one tick; r_ticks counts remaining ticks.
            if (r_dly == DLY_W'(DLY_UNIT - 1)) begin
               w_dly_nxt   = '0;
               w_ticks_nxt = r_ticks - 1'b1;
               if (r_ticks == DATA_W'(1)) begin
                  w_state_nxt = S_NEXT;
               end
            end else begin
               w_dly_nxt = r_dly + 1'b1;
            end
         end
         S_NEXT: begin
            if (r_romaddr == ROM_AW'(DEPTH - 1)) begin
               w_done_nxt  = 1'b1;
               w_state_nxt = S_DONE;
            end else begin
               w_romaddr_nxt = r_romaddr + 1'b1;
               w_state_nxt   = S_FETCH;
            end
         end
         S_DONE: begin
            w_busy_nxt  = 1'b0;
            w_state_nxt = S_IDLE;
         end
         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase

      if (w_err_inc && (r_err_cnt != '1)) begin
         w_err_cnt_nxt = r_err_cnt + 1'b1;
      end
   end

   assign o_romaddr       = r_romaddr;
   assign o_busy          = r_busy;
   assign o_done          = r_done;
   assign o_err_cnt       = r_err_cnt;
   assign sccb.sccb_req   = r_req;
   assign sccb.sccb_rw    = r_rw;
   assign sccb.sccb_addr  = r_addr;
   assign sccb.sccb_wdata = r_wdata;
endmodule

// File: tb/tb_cam_init_seq.sv
// tb/tb_cam_init_seq.sv - self-checking bench for cam_init_seq
module tb_cam_init_seq;
   localparam int ROM_AW    = 3;
   localparam int DEPTH     = 6;
   localparam int REG_AW    = 8;
   localparam int DATA_W    = 8;
   localparam int DLY_UNIT  = 10;
   localparam int DLY_W     = 8;
   localparam int MAX_RETRY = 3;
   localparam int ERR_W     = 2;
   localparam int ERR_MAX   = (1 << ERR_W) - 1;

   typedef struct packed {
      logic       rw;
      logic [7:0] addr;
      logic [7:0] data;
      logic       retry;
   } txn_t;

   logic              clk = 1'b0;
   logic              rst_n = 1'b0;
   logic              start = 1'b0;
   logic [ROM_AW-1:0] romaddr;
   logic [1:0]        t_cmd;
   logic [7:0]        t_addr;
   logic [7:0]        t_data;
   logic              busy;
   logic              done;
   logic [ERR_W-1:0]  err_cnt;

   cam_init_seq_if #(.REG_AW(REG_AW), .DATA_W(DATA_W)) bus ();

   logic [1:0] rom_cmd  [8];
   logic [7:0] rom_addr [8];
   logic [7:0] rom_data [8];
   logic [7:0] rd_mem   [256];

   assign t_cmd  = rom_cmd[romaddr];
   assign t_addr = rom_addr[romaddr];
   assign t_data = rom_data[romaddr];

   cam_init_seq #(
      .ROM_AW(ROM_AW), .DEPTH(DEPTH), .REG_AW(REG_AW), .DATA_W(DATA_W),
      .DLY_UNIT(DLY_UNIT), .DLY_W(DLY_W), .MAX_RETRY(MAX_RETRY), .ERR_W(ERR_W)
   ) dut (
      .clk(clk), .rst_n(rst_n), .i_start(start), .o_romaddr(romaddr),
      .i_t_cmd(t_cmd), .i_t_addr(t_addr), .i_t_data(t_data), .sccb(bus),
      .o_busy(busy), .o_done(done), .o_err_cnt(err_cnt)
   );

   always #5 clk = ~clk;

   int   n_chk = 0;
   int   n_err = 0;
   int   cyc = 0;
   int   sl_lat = 1, sl_nack_n = 0, sl_nack_seen = 0, sl_cnt = 0;
   bit   sl_pending = 0;
   txn_t exp_q[$];
   int   exp_err = 0;
   int   n_req, n_done, first_req_cyc, last_req_cyc, done_cyc, last_ack_cyc, s0;
   logic prev_req = 1'b0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input int act, input int exp);
      n_chk++;
      if (act != exp) begin
         n_err++;
         $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
      end
   endtask

   task automatic clear_rom();
      for (int i = 0; i < 8; i++) begin
         rom_cmd[i] = 2'd0; rom_addr[i] = 8'h00; rom_data[i] = 8'h00;
      end
   endtask

   task automatic set_rom(input int i, input logic [1:0] c, input logic [7:0] a, input logic [7:0] d);
      rom_cmd[i] = c; rom_addr[i] = a; rom_data[i] = d;
   endtask

   // Expected transaction list and error count derived from the ROM contents and slave policy.
   task automatic build_model();
      int   att;
      bit   fails;
      txn_t t;
      exp_q.delete();
      exp_err = 0;
      for (int i = 0; i < DEPTH; i++) begin
         if (rom_cmd[i] == 2'd0) break;
         if (rom_cmd[i] == 2'd2) continue;
         fails = (sl_nack_n > MAX_RETRY);
         att   = fails ? MAX_RETRY + 1 : sl_nack_n + 1;
         for (int a = 0; a < att; a++) begin
            t.rw = (rom_cmd[i] == 2'd3); t.addr = rom_addr[i]; t.data = rom_data[i]; t.retry = (a > 0);
            exp_q.push_back(t);
         end
         if (fails || (rom_cmd[i] == 2'd3 && rd_mem[rom_addr[i]] != rom_data[i]))
            if (exp_err < ERR_MAX) exp_err++;
      end
   endtask

   task automatic slave_ack();
      bus.sccb_ack   = 1'b1;
      bus.sccb_rdata = rd_mem[bus.sccb_addr];
      sl_pending     = 0;
      if (sl_nack_seen < sl_nack_n) begin
         bus.sccb_nack = 1'b1;
         sl_nack_seen++;
      end else begin
         sl_nack_seen = 0;
      end
   endtask

   // SCCB slave: acks sl_lat cycles after it first sees a request.
   initial begin
      bus.sccb_ack = 1'b0; bus.sccb_nack = 1'b0; bus.sccb_rdata = 8'h00;
      forever begin
         @(posedge clk); #1;
         bus.sccb_ack = 1'b0; bus.sccb_nack = 1'b0;
         if (!rst_n) begin
            sl_pending = 0;
         end else if (sl_pending) begin
            sl_cnt++;
            if (sl_cnt >= sl_lat) slave_ack();
         end else if (bus.sccb_req) begin
            sl_pending = 1; sl_cnt = 0;
            if (sl_lat == 0) slave_ack();
         end
      end
   end

   // Per-cycle compare against the expected transaction list.
   initial begin
      txn_t t;
      forever begin
         @(negedge clk);
         if (rst_n) begin
            if (bus.sccb_req && !prev_req) begin
               n_req++;
               if (first_req_cyc < 0) first_req_cyc = cyc;
               last_req_cyc = cyc;
               if (exp_q.size() == 0) begin
                  n_chk++; n_err++;
                  $display("FAIL unexpected_req actual_addr=%0h expected=none", bus.sccb_addr);
               end else begin
                  t = exp_q.pop_front();
                  chk("req_rw", int'(bus.sccb_rw), int'(t.rw));
                  chk("req_addr", int'(bus.sccb_addr), int'(t.addr));
                  chk("req_wdata", int'(bus.sccb_wdata), int'(t.data));
                  if (t.retry) chk("retry_gap", cyc - last_ack_cyc, 2);
               end
            end
            if (bus.sccb_ack) last_ack_cyc = cyc;
            if (done) begin
               n_done++; done_cyc = cyc;
               chk("done_err", int'(err_cnt), exp_err);
               chk("done_busy", int'(busy), 1);
            end
            if (busy) chk("romaddr_range", int'(romaddr <= ROM_AW'(DEPTH - 1)), 1);
            if (bus.sccb_req) chk("req_busy", int'(busy), 1);
         end
         prev_req = bus.sccb_req;
      end
   end

   task automatic kick(input int lat, input int nack_n);
      sl_lat = lat; sl_nack_n = nack_n; sl_nack_seen = 0;
      build_model();
      n_req = 0; n_done = 0; first_req_cyc = -1; last_req_cyc = -1; done_cyc = -1; last_ack_cyc = -100;
      @(posedge clk); #2;
      start = 1'b1; s0 = cyc + 1;
      @(posedge clk); #2;
      start = 1'b0;
   endtask

   task automatic finish_run(input bit extra_starts, input int budget);
      for (int k = 0; k < budget && n_done == 0; k++) begin
         @(posedge clk);
         if (extra_starts && (k == 6 || k == 14)) begin
            #2 start = 1'b1;
            @(posedge clk);
            #2 start = 1'b0;
         end
      end
      chk("done_seen", int'(n_done > 0), 1);
      repeat (4) @(posedge clk);
      #2;
      chk("done_once", n_done, 1);
      chk("txn_left", exp_q.size(), 0);
      chk("err_final", int'(err_cnt), exp_err);
      chk("busy_after", int'(busy), 0);
   endtask

   initial begin
      bit ok;
      clear_rom();
      for (int i = 0; i < 256; i++) rd_mem[i] = 8'h00;
      repeat (3) @(posedge clk);
      #2;
      chk("rst_romaddr", int'(romaddr), 0);
      chk("rst_req", int'(bus.sccb_req), 0);
      chk("rst_rw", int'(bus.sccb_rw), 0);
      chk("rst_addr", int'(bus.sccb_addr), 0);
      chk("rst_wdata", int'(bus.sccb_wdata), 0);
      chk("rst_busy", int'(busy), 0);
      chk("rst_done", int'(done), 0);
      chk("rst_err", int'(err_cnt), 0);
      rst_n = 1'b1;

      // two writes then END, slow slave
      set_rom(0, 2'd1, 8'h12, 8'h80);
      set_rom(1, 2'd1, 8'h11, 8'h01);
      kick(5, 0); finish_run(0, 400);
      chk("t1_n_req", n_req, 2);
      chk("t1_first_req", first_req_cyc - s0 + 1, 3);
      chk("t1_err", int'(err_cnt), 0);
      chk("t1_romaddr_hold", int'(romaddr), 2);

      // same ROM, immediate ack: 4 cycles per write entry
      kick(0, 0); finish_run(0, 400);
      chk("t1b_req2", last_req_cyc - s0 + 1, 7);
      chk("t1b_done", done_cyc - s0 + 1, 10);

      // DELAY 3 ticks of 10 cycles
      clear_rom();
      set_rom(0, 2'd2, 8'h00, 8'd3);
      kick(1, 0); finish_run(0, 400);
      chk("t2_n_req", n_req, 0);
      chk("t2_done_window", int'((done_cyc - s0 + 1) >= 33 && (done_cyc - s0 + 1) <= 35), 1);

      // DELAY 0 skips straight to the next entry
      set_rom(0, 2'd2, 8'h00, 8'd0);
      kick(1, 0); finish_run(0, 400);
      chk("t2b_done", done_cyc - s0 + 1, 4);

      // two NACKs then ACK
      clear_rom();
      set_rom(0, 2'd1, 8'h20, 8'h55);
      kick(1, 2); finish_run(0, 400);
      chk("t3_n_req", n_req, 3);
      chk("t3_err", int'(err_cnt), 0);

      // always NACK: each entry gives up after MAX_RETRY, sequence moves on
      set_rom(1, 2'd1, 8'h21, 8'h66);
      kick(0, 255); finish_run(0, 400);
      chk("t3b_n_req", n_req, 8);
      chk("t3b_err", int'(err_cnt), 2);

      // read-verify mismatch then match
      clear_rom();
      set_rom(0, 2'd3, 8'h0A, 8'h76);
      rd_mem[8'h0A] = 8'h73;
      kick(3, 0); finish_run(0, 400);
      chk("t4_err_mismatch", int'(err_cnt), 1);
      rd_mem[8'h0A] = 8'h76;
      kick(3, 0); finish_run(0, 400);
      chk("t4_err_match", int'(err_cnt), 0);

      // no END marker: stops after DEPTH entries, extra starts ignored
      for (int i = 0; i < 8; i++) set_rom(i, 2'd1, 8'(8'h40 + i), 8'(i * 3));
      kick(2, 0); finish_run(1, 600);
      chk("t5_n_req", n_req, DEPTH);
      chk("t5_romaddr_hold", int'(romaddr), DEPTH - 1);

      // asynchronous reset mid-transaction, then restart from entry 0
      clear_rom();
      set_rom(0, 2'd3, 8'h0A, 8'h76);
      set_rom(1, 2'd1, 8'h12, 8'h80);
      rd_mem[8'h0A] = 8'h73;
      kick(20, 0);
      ok = 0;
      for (int k = 0; k < 300 && !ok; k++) begin
         @(posedge clk); #2;
         ok = bus.sccb_req && (err_cnt == 2'd1);
      end
      chk("t6_setup", int'(ok), 1);
      @(posedge clk); #3;
      rst_n = 1'b0;
      #1;
      chk("t6_req", int'(bus.sccb_req), 0);
      chk("t6_busy", int'(busy), 0);
      chk("t6_err", int'(err_cnt), 0);
      chk("t6_romaddr", int'(romaddr), 0);
      repeat (2) @(posedge clk);
      #2 rst_n = 1'b1;
      kick(5, 0); finish_run(0, 400);
      chk("t6_restart_n_req", n_req, 2);
      chk("t6_restart_first", first_req_cyc - s0 + 1, 3);

      // five failing reads saturate a 2-bit counter at 3
      clear_rom();
      for (int i = 0; i < 5; i++) begin
         set_rom(i, 2'd3, 8'(8'h30 + i), 8'hAA);
         rd_mem[8'h30 + i] = 8'h00;
      end
      kick(1, 0); finish_run(0, 600);
      chk("t7_sat", int'(err_cnt), 3);
      chk("t7_n_req", n_req, 5);

      $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
      $finish;
   end
endmodule
